test_stim_sequencer: RTL and testbench

//  Self-test stimulus controller for the 3-input test datapath, out = (ain & bin) ^ cin.

---
 rtl/test_stim_pkg.sv | 29 ++
 rtl/test_stim_patgen.sv | 59 +++++
 rtl/test_stim_sequencer.sv | 176 +++++++++++++++++
 tb/tb_test_stim_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/test_stim_pkg.sv
// Shared types and constants for the test stimulus sequencer.
// The optional LFSR pattern mode is enabled by the TEST_STIM_LFSR_EN macro.
package test_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_BIN  = 2'd0;
  localparam logic [1:0] MODE_GRAY = 2'd1;
  localparam logic [1:0] MODE_LFSR = 2'd2;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11. The register shifts right, so
  // those taps sit at bit positions 0,2,3,5 and the feedback enters at bit 15.
  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] state);
    return {^(state & LFSR_TAP_MASK), state[15:1]};
  endfunction

  // Reference behaviour of the datapath under test: out = (a & b) ^ c.
  function automatic logic expected_out(input logic [2:0] abc);
    return (abc[2] & abc[1]) ^ abc[0];
  endfunction

endpackage

// File: rtl/test_stim_patgen.sv
// Pattern generator: maps a step index and mode to the {ain,bin,cin} stimulus.
// With TEST_STIM_LFSR_EN defined it also owns the LFSR register; the pattern
// is computed from the LFSR value the register will hold after this cycle, so
// the top can register the result alongside its own step decision.
module test_stim_patgen
  import test_stim_pkg::*;
(
`ifdef TEST_STIM_LFSR_EN
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic       i_shift,
`endif
  input  logic [2:0] i_index,
  input  logic [1:0] i_mode,
  output logic [2:0] o_abc
);

`ifdef TEST_STIM_LFSR_EN
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_nx;

  // Next LFSR value: reload at each pass start, advance once per step.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the
    // variable unassigned; otherwise synthesis infers a latch.
    w_lfsr_nx = r_lfsr;
    if (i_load) begin
      w_lfsr_nx = LFSR_SEED;
    end else if (i_shift) begin
      w_lfsr_nx = lfsr_step(r_lfsr);
    end
  end

  // LFSR state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= w_lfsr_nx;
    end
  end
`endif

  // Pattern selection; unsupported modes fall back to binary counting.
  always_comb begin
    o_abc = i_index;
    case (i_mode)
      MODE_GRAY: o_abc = i_index ^ (i_index >> 1);
`ifdef TEST_STIM_LFSR_EN
      MODE_LFSR: o_abc = w_lfsr_nx[2:0];
`endif
      default:   o_abc = i_index;
    endcase
  end

endmodule

// File: rtl/test_stim_sequencer.sv
// Self-test stimulus controller for the datapath out = (ain & bin) ^ cin.
// Steps through 8 patterns per pass at a programmable rate, checks the fed-back
// datapath output at the last cycle of each step and counts mismatches.
// Optional mode 2 (LFSR patterns) is enabled by defining TEST_STIM_LFSR_EN.
module test_stim_sequencer
  import test_stim_pkg::*;
#(
  parameter int DIV_W  = 16,
  parameter int LOOP_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [DIV_W-1:0]  div,
  input  logic [LOOP_W-1:0] loops,
  input  logic [1:0]        mode,
  input  logic              out_fb,
  output logic              ain,
  output logic              bin,
  output logic              cin,
  output logic              step_strobe,
  output logic              trig_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt
);

  state_t            r_state;
  logic [DIV_W-1:0]  r_div_q;
  logic [LOOP_W-1:0] r_loops_q;
  logic [1:0]        r_mode_q;
  logic [2:0]        r_index;
  logic [LOOP_W-1:0] r_pass;
  logic [DIV_W-1:0]  r_presc;
  logic [ERR_W-1:0]  r_err_cnt;
  logic [2:0]        r_abc;
  logic              r_step_strobe;
  logic              r_trig;
  logic              r_busy;
  logic              r_done;

  logic              w_start_ok;
  logic              w_step_end;
  logic              w_last_pass;
  logic              w_mismatch;
  logic [2:0]        w_pg_index;
  logic [1:0]        w_pg_mode;
  logic [2:0]        w_pat;

  assign w_start_ok  = (r_state == ST_IDLE) && start && !stop;
  assign w_step_end  = (r_state == ST_RUN) && (r_presc == r_div_q);
  assign w_last_pass = (r_loops_q != '0) && (r_pass == r_loops_q - 1'b1);
  assign w_mismatch  = out_fb != expected_out(r_abc);

  // Index of the pattern to be driven next cycle. From IDLE it is always 0;
  // in RUN index 7 + 1 wraps to 0, which is exactly the next pass start.
  assign w_pg_index  = (r_state == ST_RUN) ? r_index + 3'd1 : 3'd0;
  assign w_pg_mode   = (r_state == ST_IDLE) ? mode : r_mode_q;

`ifdef TEST_STIM_LFSR_EN
  logic w_lfsr_load;
  logic w_lfsr_shift;

  assign w_lfsr_load  = w_start_ok ||
                        (w_step_end && !stop && (r_index == 3'd7) && !w_last_pass);
  assign w_lfsr_shift = w_step_end && !stop && (r_index != 3'd7);
`endif

  test_stim_patgen u_patgen (
`ifdef TEST_STIM_LFSR_EN
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_lfsr_load),
    .i_shift (w_lfsr_shift),
`endif
    .i_index (w_pg_index),
    .i_mode  (w_pg_mode),
    .o_abc   (w_pat)
  );

  // Sequencer FSM with registered stimulus, strobes and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_div_q       <= '0;
      r_loops_q     <= '0;
      r_mode_q      <= MODE_BIN;
      r_index       <= '0;
      r_pass        <= '0;
      r_presc       <= '0;
      r_err_cnt     <= '0;
      r_abc         <= '0;
      r_step_strobe <= 1'b0;
      r_trig        <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      // Strobes are single-cycle pulses unless re-asserted below.
      r_step_strobe <= 1'b0;
      r_trig        <= 1'b0;
      r_done        <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_div_q       <= div;
            r_loops_q     <= loops;
            r_mode_q      <= mode;
            r_index       <= '0;
            r_pass        <= '0;
            r_presc       <= '0;
            r_err_cnt     <= '0;
            r_abc         <= w_pat;
            r_step_strobe <= 1'b1;
            r_trig        <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (stop) begin
            // Abort: drop stimulus, keep the error count for inspection.
            r_abc   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_step_end) begin
            if (w_mismatch && (r_err_cnt != '1)) begin
              r_err_cnt <= r_err_cnt + 1'b1;
            end
            r_presc <= '0;
            if (r_index != 3'd7) begin
              r_index       <= r_index + 3'd1;
              r_abc         <= w_pat;
              r_step_strobe <= 1'b1;
            end else if (w_last_pass) begin
              r_abc   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              // Free-running runs (loops == 0) let the pass counter wrap.
              r_pass        <= r_pass + 1'b1;
              r_index       <= '0;
              r_abc         <= w_pat;
              r_step_strobe <= 1'b1;
              r_trig        <= 1'b1;
            end
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign {ain, bin, cin} = r_abc;
  assign step_strobe     = r_step_strobe;
  assign trig_out        = r_trig;
  assign busy            = r_busy;
  assign done            = r_done;
  assign err_cnt         = r_err_cnt;
  assign err             = |r_err_cnt;

endmodule

// File: tb/tb_test_stim_sequencer.sv
// Self-checking bench for test_stim_sequencer. A behavioural model enumerates
// passes, steps and cycles-per-step and predicts every output cycle by cycle.
// Mode 2 is modelled as LFSR patterns when TEST_STIM_LFSR_EN is defined.
module tb_test_stim_sequencer;

  localparam int DIV_W  = 16;
  localparam int LOOP_W = 8;
  localparam int ERR_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              stop;
  logic [DIV_W-1:0]  div;
  logic [LOOP_W-1:0] loops;
  logic [1:0]        mode;
  logic              out_fb;
  logic              ain, bin, cin;
  logic              step_strobe, trig_out, busy, done, err;
  logic [ERR_W-1:0]  err_cnt;

  int n_err = 0;
  int n_chk = 0;
  int fb_mode = 0;  // 0 golden datapath, 1 tied low, 2 inverted

  test_stim_sequencer #(.DIV_W(DIV_W), .LOOP_W(LOOP_W), .ERR_W(ERR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .div         (div),
    .loops       (loops),
    .mode        (mode),
    .out_fb      (out_fb),
    .ain         (ain),
    .bin         (bin),
    .cin         (cin),
    .step_strobe (step_strobe),
    .trig_out    (trig_out),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  // Datapath stand-in driven from the DUT stimulus.
  always_comb begin
    case (fb_mode)
      1:       out_fb = 1'b0;
      2:       out_fb = ~((ain & bin) ^ cin);
      default: out_fb = (ain & bin) ^ cin;
    endcase
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed={abc,stb,trg,bsy,dn,err,cnt}=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] observed();
    return {ain, bin, cin, step_strobe, trig_out, busy, done, err, err_cnt};
  endfunction

  function automatic logic [15:0] predicted(input logic [2:0] abc, input bit stb, input bit trg,
                                            input bit bsy, input bit dn, input int cnt);
    logic [7:0] c8;
    c8 = 8'(cnt);
    return {abc, stb, trg, bsy, dn, (cnt != 0), c8};
  endfunction

  function automatic logic [15:0] m_lfsr_next(input logic [15:0] s);
    logic b;
    b = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {b, s[15:1]};
  endfunction

  function automatic logic [2:0] m_pattern(input int md, input int i, input logic [15:0] l);
    logic [2:0] p;
    p = 3'(i);
    if (md == 1) p = 3'(i ^ (i >> 1));
`ifdef TEST_STIM_LFSR_EN
    if (md == 2) p = l[2:0];
`else
    if (md == 2) p = l[2:0] & 3'b000 | 3'(i);
`endif
    return p;
  endfunction

  // One run: start with the given config, then predict every cycle.
  // stop_after / restart_at are cycle offsets from the first RUN cycle (-1 = none).
  task automatic run(input string name, input int d, input int lp, input int md, input int fbm,
                     input int stop_after, input int restart_at);
    int          errs = 0;
    int          cyc = 0;
    int          np;
    bit          fin = 0;
    bit          want, got;
    logic [15:0] l;
    logic [2:0]  pat;
    fb_mode = fbm;
    @(negedge clk);
    div = 16'(d); loops = 8'(lp); mode = 2'(md); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble config inputs: the run must use the latched values.
    div = 16'($urandom); loops = 8'($urandom); mode = 2'($urandom);
    np = (lp == 0) ? 1000 : lp;
    for (int p = 0; p < np && !fin; p++) begin
      l = 16'hACE1;
      for (int i = 0; i < 8 && !fin; i++) begin
        pat = m_pattern(md, i, l);
        for (int c = 0; c <= d; c++) begin
          check({name, "_run"}, observed(), predicted(pat, c == 0, (c == 0) && (i == 0), 1, 0, errs));
          start = (cyc == restart_at);
          if (cyc == stop_after) begin
            stop = 1'b1; start = 1'b0; fin = 1;
            @(negedge clk);
            stop = 1'b0;
            break;
          end
          if (c == d) begin
            want = (pat[2] & pat[1]) ^ pat[0];
            got  = (fbm == 1) ? 1'b0 : (fbm == 2) ? ~want : want;
            if (got != want && errs < 255) errs++;
          end
          @(negedge clk);
          cyc++;
        end
        l = m_lfsr_next(l);
      end
    end
    start = 1'b0;
    if (!fin) begin
      check({name, "_done"}, observed(), predicted(3'b000, 0, 0, 0, 1, errs));
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      check({name, "_idle"}, observed(), predicted(3'b000, 0, 0, 0, 0, errs));
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    div = '0; loops = '0; mode = '0;
    repeat (2) @(negedge clk);
    check("reset", observed(), 16'h0000);
    rst_n = 1'b1;

    // Directed scenarios.
    run("bin_div0",  0, 1, 0, 0, -1, -1);
    run("gray_div3", 3, 2, 1, 0, -1, 20);
    run("fb_zero",   0, 1, 0, 1, -1, -1);
    run("loops0",    1, 0, 0, 0, 20, -1);
    run("stop_wrap", 0, 0, 1, 0, 30, -1);
    run("saturate",  0, 40, 0, 2, -1, -1);
    run("mode2",     0, 1, 2, 0, -1, -1);
    run("mode3",     1, 1, 3, 1, -1, -1);

    // Mid-run reset clears everything.
    @(negedge clk);
    div = 16'd2; loops = 8'd3; mode = 2'd1; fb_mode = 2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_reset", observed(), 16'h0000);

    // Simultaneous start and stop in IDLE: stop wins.
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("start_stop", observed(), 16'h0000);
    @(negedge clk);
    check("start_stop_hold", observed(), 16'h0000);

    // Randomised runs against the model.
    for (int r = 0; r < 8; r++) begin
      run("rand", int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
          (r % 3 == 2) ? int'($urandom_range(0, 15)) : -1,
          int'($urandom_range(0, 12)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
